mem_port_arb: RTL and testbench

- Shares one memory request/response port between the instruction-fetch side (IFU fetch bus) and the data side (LSU).
- Arbitrates requests, locks a grant until the request is accepted, and tracks in-flight transactions in an in-order owner FIFO.
- Routes each memory response back to its requester. Fetch responses in flight when a pipeline flush occurs are discarded.
- Sits between the core's imem/dmem buses and the single SRAM/bus port.

---
 rtl/mem_port_arb_if.sv | 58 +++++
 rtl/mem_port_arb.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
// Signal bundle between the core's fetch/data buses, the shared memory port and the arbiter.
// The arbiter uses the slave modport; the surrounding core/memory environment uses master.
interface mem_port_arb_if #(
    parameter int unsigned MAX_OUTS = 2
) ();
    localparam int unsigned CntW = $clog2(MAX_OUTS) + 1;

    logic            flush;

    logic            i_req_valid;
    logic            i_req_ready;
    logic [31:0]     i_req_addr;
    logic            i_resp_valid;
    logic [31:0]     i_resp_data;

    logic            d_req_valid;
    logic            d_req_ready;
    logic            d_req_type;
    logic [31:0]     d_req_addr;
    logic [31:0]     d_req_wdata;
    logic [3:0]      d_req_mask;
    logic            d_resp_valid;
    logic [31:0]     d_resp_data;

    logic            m_req_valid;
    logic            m_req_ready;
    logic            m_req_type;
    logic [31:0]     m_req_addr;
    logic [31:0]     m_req_wdata;
    logic [3:0]      m_req_mask;
    logic            m_resp_valid;
    logic [31:0]     m_resp_data;

    logic [CntW-1:0] outs_cnt;
    logic            resp_err;

    modport master (
        output flush,
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_type, d_req_addr, d_req_wdata, d_req_mask,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  m_req_valid, m_req_type, m_req_addr, m_req_wdata, m_req_mask,
        output m_req_ready, m_resp_valid, m_resp_data,
        input  outs_cnt, resp_err
    );

    modport slave (
        input  flush,
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_type, d_req_addr, d_req_wdata, d_req_mask,
        output d_req_ready, d_resp_valid, d_resp_data,
        output m_req_valid, m_req_type, m_req_addr, m_req_wdata, m_req_mask,
        input  m_req_ready, m_resp_valid, m_resp_data,
        output outs_cnt, resp_err
    );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one memory port between instruction fetch and data access: arbitration with grant lock
// and starvation guard, plus an in-order owner FIFO that routes responses back to the requester.
module mem_port_arb #(
    parameter int unsigned MAX_OUTS     = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rstn,
    mem_port_arb_if.slave bus
);
    localparam int unsigned CntW = $clog2(MAX_OUTS) + 1;
    localparam int unsigned PtrW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTS);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTS - 1);
    localparam logic [StW-1:0]  StMax   = StW'(STARVE_LIMIT);

    typedef enum logic {
        OwnI = 1'b0,
        OwnD = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        StFree,
        StLockI,
        StLockD
    } lock_e;

    lock_e               lock_q, lock_d;
    owner_e              sel;
    logic                sel_valid;
    logic                full;
    logic                m_valid;
    logic                accept;
    logic                pop;
    logic [StW-1:0]      starve_q, starve_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTS-1:0] owner_q, owner_d;  // 1 = data side
    logic [MAX_OUTS-1:0] disc_q, disc_d;
    logic                resp_err_q, resp_err_d;
    logic                head_own_d;
    logic                head_disc;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Selection: a held lock wins, otherwise data side unless fetch has starved long enough.
    always_comb begin
        sel = OwnD;
        unique case (lock_q)
            StLockI: sel = OwnI;
            StLockD: sel = OwnD;
            default: begin
                if (bus.i_req_valid && (!bus.d_req_valid || starve_q == StMax)) begin
                    sel = OwnI;
                end
            end
        endcase
    end

    assign sel_valid = (sel == OwnI) ? bus.i_req_valid : bus.d_req_valid;
    assign full      = (cnt_q == CntMax);
    assign m_valid   = sel_valid && !full;
    assign accept    = m_valid && bus.m_req_ready;

    assign bus.m_req_valid = m_valid;
    assign bus.m_req_type  = (sel == OwnD) ? bus.d_req_type  : 1'b0;
    assign bus.m_req_addr  = (sel == OwnD) ? bus.d_req_addr  : bus.i_req_addr;
    assign bus.m_req_wdata = (sel == OwnD) ? bus.d_req_wdata : 32'h0;
    assign bus.m_req_mask  = (sel == OwnD) ? bus.d_req_mask  : 4'h0;
    assign bus.i_req_ready = bus.m_req_ready && !full && (sel == OwnI);
    assign bus.d_req_ready = bus.m_req_ready && !full && (sel == OwnD);

    always_comb begin
        lock_d = lock_q;
        unique case (lock_q)
            StFree: begin
                if (m_valid && !bus.m_req_ready) begin
                    lock_d = (sel == OwnI) ? StLockI : StLockD;
                end
            end
            // A requester dropping valid while locked is a protocol error; release to avoid a hang.
            StLockI: begin
                if (accept || !bus.i_req_valid || bus.flush) begin
                    lock_d = StFree;
                end
            end
            StLockD: begin
                if (accept || !bus.d_req_valid) begin
                    lock_d = StFree;
                end
            end
            default: lock_d = StFree;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (bus.i_req_valid && accept && (sel == OwnD)) begin
            starve_d = (starve_q == StMax) ? starve_q : starve_q + 1'b1;
        end else if (!bus.i_req_valid || (accept && (sel == OwnI))) begin
            starve_d = '0;
        end
    end

    assign pop        = bus.m_resp_valid && (cnt_q != '0);
    assign resp_err_d = resp_err_q || (bus.m_resp_valid && (cnt_q == '0));

    always_comb begin
        owner_d  = owner_q;
        disc_d   = disc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Marking empty fetch slots too is harmless: a push rewrites the discard bit.
        if (bus.flush) begin
            disc_d = disc_q | ~owner_q;
        end
        if (accept) begin
            owner_d[wr_ptr_q] = (sel == OwnD);
            disc_d[wr_ptr_q]  = bus.flush && (sel == OwnI);
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign head_own_d = owner_q[rd_ptr_q];
    assign head_disc  = disc_q[rd_ptr_q];

    // A response arriving in the flush cycle is dropped even before its discard bit registers.
    assign bus.d_resp_valid = pop && head_own_d;
    assign bus.i_resp_valid = pop && !head_own_d && !head_disc && !bus.flush;
    assign bus.d_resp_data  = bus.m_resp_data;
    assign bus.i_resp_data  = bus.m_resp_data;

    assign bus.outs_cnt = cnt_q;
    assign bus.resp_err = resp_err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lock_q     <= StFree;
            starve_q   <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            owner_q    <= '0;
            disc_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            starve_q   <= starve_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            owner_q    <= owner_d;
            disc_q     <= disc_d;
            resp_err_q <= resp_err_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a per-cycle vector table plus contention and mid-reset sequences.
module tb_mem_port_arb;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] Z = 32'h0;
    localparam int NVec = 27;

    typedef struct packed {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic        dt;
        logic [31:0] da;
        logic [31:0] dw;
        logic [3:0]  dm;
        logic        mr;
        logic        rv;
        logic [31:0] rd;
        logic        fl;
    } stim_t;

    typedef struct packed {
        logic        mv;
        logic        mt;
        logic [31:0] ma;
        logic [31:0] mw;
        logic [3:0]  mm;
        logic        ir;
        logic        dr;
        logic        iv;
        logic        dv;
        logic [1:0]  cnt;
        logic        err;
    } exp_t;

    typedef struct packed {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NVec];
    logic prev_v, prev_i, exp_i;

    always #5 clk = ~clk;

    mem_port_arb_if #(.MAX_OUTS(2)) bus ();

    mem_port_arb #(
        .MAX_OUTS    (2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    function automatic void chk(input string name, input int idx, input logic [127:0] got,
                                input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, got, exp);
        end
    endfunction

    task automatic drive(input stim_t s);
        bus.i_req_valid  = s.iv;
        bus.i_req_addr   = s.ia;
        bus.d_req_valid  = s.dv;
        bus.d_req_type   = s.dt;
        bus.d_req_addr   = s.da;
        bus.d_req_wdata  = s.dw;
        bus.d_req_mask   = s.dm;
        bus.m_req_ready  = s.mr;
        bus.m_resp_valid = s.rv;
        bus.m_resp_data  = s.rd;
        bus.flush        = s.fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        chk("m_req_valid", idx, 128'(bus.m_req_valid), 128'(v.e.mv));
        if (v.e.mv) begin
            chk("m_req_payload", idx,
                128'({bus.m_req_type, bus.m_req_addr, bus.m_req_wdata, bus.m_req_mask}),
                128'({v.e.mt, v.e.ma, v.e.mw, v.e.mm}));
        end
        chk("req_ready", idx, 128'({bus.i_req_ready, bus.d_req_ready}), 128'({v.e.ir, v.e.dr}));
        chk("resp_valid", idx, 128'({bus.i_resp_valid, bus.d_resp_valid}),
            128'({v.e.iv, v.e.dv}));
        if (v.e.iv) chk("i_resp_data", idx, 128'(bus.i_resp_data), 128'(v.s.rd));
        if (v.e.dv) chk("d_resp_data", idx, 128'(bus.d_resp_data), 128'(v.s.rd));
        chk("status", idx, 128'({bus.outs_cnt, bus.resp_err}), 128'({v.e.cnt, v.e.err}));
    endtask

    initial begin
        // stim: iv ia dv dt da dw dm mr rv rd fl | exp: mv mt ma mw mm ir dr iv dv cnt err
        // Idle, then a single fetch and its response two cycles later.
        vecs[0].s  = '{L, Z, L, L, Z, Z, 4'h0, L, L, Z, L};
        vecs[0].e  = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd0, L};
        vecs[1].s  = '{H, 32'h100, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[1].e  = '{H, L, 32'h100, Z, 4'h0, H, L, L, L, 2'd0, L};
        vecs[2].s  = '{L, Z, L, L, Z, Z, 4'h0, L, L, Z, L};
        vecs[2].e  = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd1, L};
        vecs[3].s  = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'hDEADBEEF, L};
        vecs[3].e  = '{L, L, Z, Z, 4'h0, L, L, H, L, 2'd1, L};
        vecs[4].s  = '{L, Z, L, L, Z, Z, 4'h0, L, L, Z, L};
        vecs[4].e  = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd0, L};
        // Backpressured data write holds its grant while fetch joins; fetch goes next.
        vecs[5].s  = '{L, Z, H, H, 32'h200, 32'h11223344, 4'hF, L, L, Z, L};
        vecs[5].e  = '{H, H, 32'h200, 32'h11223344, 4'hF, L, L, L, L, 2'd0, L};
        vecs[6].s  = '{H, 32'h300, H, H, 32'h200, 32'h11223344, 4'hF, L, L, Z, L};
        vecs[6].e  = '{H, H, 32'h200, 32'h11223344, 4'hF, L, L, L, L, 2'd0, L};
        vecs[7].s  = '{H, 32'h300, H, H, 32'h200, 32'h11223344, 4'hF, L, L, Z, L};
        vecs[7].e  = '{H, H, 32'h200, 32'h11223344, 4'hF, L, L, L, L, 2'd0, L};
        vecs[8].s  = '{H, 32'h300, H, H, 32'h200, 32'h11223344, 4'hF, H, L, Z, L};
        vecs[8].e  = '{H, H, 32'h200, 32'h11223344, 4'hF, L, H, L, L, 2'd0, L};
        vecs[9].s  = '{H, 32'h300, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[9].e  = '{H, L, 32'h300, Z, 4'h0, H, L, L, L, 2'd1, L};
        vecs[10].s = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'hAAAA0001, L};
        vecs[10].e = '{L, L, Z, Z, 4'h0, L, L, L, H, 2'd2, L};
        vecs[11].s = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'hAAAA0002, L};
        vecs[11].e = '{L, L, Z, Z, 4'h0, L, L, H, L, 2'd1, L};
        // Full FIFO blocks a third fetch; a response frees the slot for the next cycle.
        vecs[12].s = '{H, 32'h400, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[12].e = '{H, L, 32'h400, Z, 4'h0, H, L, L, L, 2'd0, L};
        vecs[13].s = '{H, 32'h404, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[13].e = '{H, L, 32'h404, Z, 4'h0, H, L, L, L, 2'd1, L};
        vecs[14].s = '{H, 32'h408, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[14].e = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd2, L};
        vecs[15].s = '{H, 32'h408, L, L, Z, Z, 4'h0, H, H, 32'h400, L};
        vecs[15].e = '{L, L, Z, Z, 4'h0, L, L, H, L, 2'd2, L};
        vecs[16].s = '{H, 32'h408, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[16].e = '{H, L, 32'h408, Z, 4'h0, H, L, L, L, 2'd1, L};
        vecs[17].s = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h404, L};
        vecs[17].e = '{L, L, Z, Z, 4'h0, L, L, H, L, 2'd2, L};
        vecs[18].s = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h408, L};
        vecs[18].e = '{L, L, Z, Z, 4'h0, L, L, H, L, 2'd1, L};
        // Flush: I then D outstanding, flush, I accepted during a second flush; only D answers.
        vecs[19].s = '{H, 32'h500, L, L, Z, Z, 4'h0, H, L, Z, L};
        vecs[19].e = '{H, L, 32'h500, Z, 4'h0, H, L, L, L, 2'd0, L};
        vecs[20].s = '{L, Z, H, L, 32'h600, Z, 4'h0, H, L, Z, L};
        vecs[20].e = '{H, L, 32'h600, Z, 4'h0, L, H, L, L, 2'd1, L};
        vecs[21].s = '{L, Z, L, L, Z, Z, 4'h0, L, L, Z, H};
        vecs[21].e = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd2, L};
        vecs[22].s = '{H, 32'h504, L, L, Z, Z, 4'h0, H, H, 32'h500, L};
        vecs[22].e = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd2, L};
        vecs[23].s = '{H, 32'h504, L, L, Z, Z, 4'h0, H, L, Z, H};
        vecs[23].e = '{H, L, 32'h504, Z, 4'h0, H, L, L, L, 2'd1, L};
        vecs[24].s = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h600, L};
        vecs[24].e = '{L, L, Z, Z, 4'h0, L, L, L, H, 2'd2, L};
        vecs[25].s = '{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h504, L};
        vecs[25].e = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd1, L};
        vecs[26].s = '{L, Z, L, L, Z, Z, 4'h0, L, L, Z, L};
        vecs[26].e = '{L, L, Z, Z, 4'h0, L, L, L, L, 2'd0, L};

        rstn = 1'b0;
        drive('0);
        step();
        step();
        rstn = 1'b1;

        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].s);
            #1;
            check_vec(i, vecs[i]);
            step();
        end

        // Continuous contention, latency-1 memory: grants D,D,D,D,I repeating.
        prev_v = 1'b0;
        prev_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            exp_i = (k == 4) || (k == 9);
            drive('{H, 32'h1000 + 32'(k), H, L, 32'h2000 + 32'(k), Z, 4'h0, H, prev_v,
                    32'(k), L});
            #1;
            chk("grant", 100 + k, 128'({bus.i_req_ready, bus.d_req_ready}),
                128'({exp_i, !exp_i}));
            chk("grant_addr", 100 + k, 128'(bus.m_req_addr),
                128'(exp_i ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k)));
            chk("contend_resp", 100 + k, 128'({bus.i_resp_valid, bus.d_resp_valid}),
                128'({prev_v && prev_i, prev_v && !prev_i}));
            prev_v = 1'b1;
            prev_i = exp_i;
            step();
        end
        drive('{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h9, L});
        #1;
        chk("contend_tail", 110, 128'({bus.i_resp_valid, bus.d_resp_valid}), 128'(2'b10));
        step();
        drive('0);
        #1;
        chk("contend_cnt", 111, 128'(bus.outs_cnt), 128'(2'd0));

        // Reset with two outstanding; later responses hit an empty FIFO.
        drive('{H, 32'h700, L, L, Z, Z, 4'h0, H, L, Z, L});
        step();
        drive('{H, 32'h704, L, L, Z, Z, 4'h0, H, L, Z, L});
        step();
        drive('0);
        #1;
        chk("pre_reset_cnt", 200, 128'(bus.outs_cnt), 128'(2'd2));
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        chk("post_reset", 201, 128'({bus.outs_cnt, bus.resp_err}), 128'(3'b000));
        drive('{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h77, L});
        #1;
        chk("orphan_resp1", 202, 128'({bus.i_resp_valid, bus.d_resp_valid}), 128'(2'b00));
        step();
        drive('0);
        #1;
        chk("err_set", 203, 128'({bus.outs_cnt, bus.resp_err}), 128'(3'b001));
        drive('{L, Z, L, L, Z, Z, 4'h0, L, H, 32'h78, L});
        #1;
        chk("orphan_resp2", 204, 128'({bus.i_resp_valid, bus.d_resp_valid}), 128'(2'b00));
        step();
        drive('0);
        #1;
        chk("err_sticky", 205, 128'({bus.outs_cnt, bus.resp_err}), 128'(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
